// File: rtl/gci_pkg.sv
// gci_pkg: shared definitions for the GCI hub router slice.
//   - Router FSM state encoding.
//   - Node count and node-register offsets.
//   - Window-end helper used while building the address map.
package gci_pkg;

  localparam int GCI_NODE_NUM   = 4;
  localparam int GCI_NODE_IDX_W = 2;

  // Register offsets inside each node's local address space.
  localparam logic [31:0] GCI_REG_MEMSIZE  = 32'h0000_0000;
  localparam logic [31:0] GCI_REG_PRIORITY = 32'h0000_0004;
  localparam logic [31:0] GCI_REG_INTFLAG  = 32'h0000_0008;

  // One past the last byte of the 32-bit global space.
  localparam logic [32:0] GCI_ADDR_TOP = 33'h1_0000_0000;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_BUILD = 3'd1,
    ST_IDLE  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RESP  = 3'd5
  } gci_hub_state_t;

  // base <= 2^32 and size < 2^32, so the sum always fits in 33 bits;
  // anything past the top of the global space is pinned to 2^32 so later
  // bases can never wrap back into valid addresses.
  function automatic logic [32:0] gci_clip_end(input logic [32:0] base,
                                               input logic [31:0] size);
    logic [32:0] sum;
    sum = base + {1'b0, size};
    if (sum > GCI_ADDR_TOP) begin
      return GCI_ADDR_TOP;
    end
    return sum;
  endfunction

endpackage

// File: rtl/gci_hub_router_if.sv
// gci_hub_router_if: master-side bus plus the four-node fan-out of the router.
//   Signal names are from the router's point of view (i* = into the router).
//   modport slave  : the router itself.
//   modport master : the environment (bus master and the nodes).
interface gci_hub_router_if;
  import gci_pkg::*;

  // Master side
  logic                           iMASTER_REQ;
  logic                           oMASTER_BUSY;
  logic                           iMASTER_RW;
  logic [31:0]                    iMASTER_ADDR;
  logic [31:0]                    iMASTER_DATA;
  logic                           oMASTER_REQ;
  logic                           iMASTER_BUSY;
  logic [31:0]                    oMASTER_DATA;
  logic                           oMASTER_ERR;
  logic                           oREADY;

  // Node side
  logic [GCI_NODE_NUM-1:0]        iNODE_VALID;
  logic [GCI_NODE_NUM-1:0]        iNODEINFO_VALID;
  logic [32*GCI_NODE_NUM-1:0]     iNODEINFO_MEMSIZE;
  logic [GCI_NODE_NUM-1:0]        oNODE_REQ;
  logic [GCI_NODE_NUM-1:0]        iNODE_BUSY;
  logic                           oNODE_RW;
  logic [31:0]                    oNODE_ADDR;
  logic [31:0]                    oNODE_DATA;
  logic [GCI_NODE_NUM-1:0]        iNODE_REQ;
  logic [32*GCI_NODE_NUM-1:0]     iNODE_DATA;

  modport slave (
    input  iMASTER_REQ, iMASTER_RW, iMASTER_ADDR, iMASTER_DATA, iMASTER_BUSY,
    output oMASTER_BUSY, oMASTER_REQ, oMASTER_DATA, oMASTER_ERR, oREADY,
    input  iNODE_VALID, iNODEINFO_VALID, iNODEINFO_MEMSIZE, iNODE_BUSY,
    input  iNODE_REQ, iNODE_DATA,
    output oNODE_REQ, oNODE_RW, oNODE_ADDR, oNODE_DATA
  );

  modport master (
    output iMASTER_REQ, iMASTER_RW, iMASTER_ADDR, iMASTER_DATA, iMASTER_BUSY,
    input  oMASTER_BUSY, oMASTER_REQ, oMASTER_DATA, oMASTER_ERR, oREADY,
    output iNODE_VALID, iNODEINFO_VALID, iNODEINFO_MEMSIZE, iNODE_BUSY,
    output iNODE_REQ, iNODE_DATA,
    input  oNODE_REQ, oNODE_RW, oNODE_ADDR, oNODE_DATA
  );

endinterface

// File: rtl/gci_hub_addr_decoder.sv
// gci_hub_addr_decoder: combinational global-to-node address decode.
//   base_i  : latched window bases (33 bit, at most 2^32).
//   size_i  : latched effective sizes (0 for absent nodes).
//   addr_i  : global address.
//   hit_o   : some node owns addr_i.
//   owner_o : lowest-index owning node.
//   local_o : addr_i - base(owner).
module gci_hub_addr_decoder
  import gci_pkg::*;
(
  input  logic [GCI_NODE_NUM-1:0][32:0] base_i,
  input  logic [GCI_NODE_NUM-1:0][31:0] size_i,
  input  logic [31:0]                   addr_i,
  output logic                          hit_o,
  output logic [GCI_NODE_IDX_W-1:0]     owner_o,
  output logic [31:0]                   local_o
);

  // Walk from the top index down so the lowest matching node wins.
  // A zero-size window has base == end and can never match.
  always_comb begin
    hit_o   = 1'b0;
    owner_o = '0;
    local_o = '0;
    for (int i = GCI_NODE_NUM - 1; i >= 0; i--) begin
      if (({1'b0, addr_i} >= base_i[i]) &&
          ({2'b00, addr_i} < ({1'b0, base_i[i]} + {2'b00, size_i[i]}))) begin
        hit_o   = 1'b1;
        owner_o = GCI_NODE_IDX_W'(i);
        local_o = addr_i - base_i[i][31:0];
      end
    end
  end

endmodule

// File: rtl/gci_hub_router.sv
// gci_hub_router: single-outstanding master-to-node router.
//   iCLOCK, iRESET : clock and asynchronous active-high reset.
//   bus            : master request/completion handshake plus per-node
//                    request/completion, size info and broadcast addr/data.
// Builds an address map from the node sizes once all present nodes report
// ready, then forwards each master request to its owning node with a
// node-local address. Unmapped addresses and node timeouts complete with
// UNMAPPED_DATA and an error flag.
module gci_hub_router
  import gci_pkg::*;
#(
  parameter logic [7:0]  TIMEOUT_CYCLE = 8'hFF,
  parameter logic [31:0] UNMAPPED_DATA = 32'hFFFF_FFFF
) (
  input logic             iCLOCK,
  input logic             iRESET,
  gci_hub_router_if.slave bus
);

  gci_hub_state_t                 state_q, state_d;
  logic                           rw_q, rw_d;
  logic [31:0]                    addr_q, addr_d;
  logic [31:0]                    wdata_q, wdata_d;
  logic [GCI_NODE_IDX_W-1:0]      owner_q, owner_d;
  logic [7:0]                     cnt_q, cnt_d;
  logic [31:0]                    rdata_q, rdata_d;
  logic                           err_q, err_d;
  logic [GCI_NODE_NUM-1:0][32:0]  base_q, base_d;
  logic [GCI_NODE_NUM-1:0][31:0]  size_q, size_d;

  logic [GCI_NODE_NUM-1:0][31:0]  memsize;
  logic [GCI_NODE_NUM-1:0][31:0]  node_data;
  logic [GCI_NODE_NUM-1:0][31:0]  size_eff;
  logic [GCI_NODE_NUM-1:0][32:0]  base_calc;
  logic                           all_ready;
  logic                           dec_hit;
  logic [GCI_NODE_IDX_W-1:0]      dec_owner;
  logic [31:0]                    dec_local;
  logic [7:0]                     cnt_nxt;
  logic [GCI_NODE_NUM-1:0]        node_req;

  assign memsize   = bus.iNODEINFO_MEMSIZE;
  assign node_data = bus.iNODE_DATA;

  // Absent nodes contribute nothing to the map regardless of reported size.
  assign all_ready = &(~bus.iNODE_VALID | bus.iNODEINFO_VALID);

  always_comb begin
    logic [32:0] acc;
    acc = '0;
    for (int i = 0; i < GCI_NODE_NUM; i++) begin
      size_eff[i]  = bus.iNODE_VALID[i] ? memsize[i] : 32'h0;
      base_calc[i] = acc;
      acc          = gci_clip_end(acc, size_eff[i]);
    end
  end

  gci_hub_addr_decoder u_dec (
    .base_i  (base_q),
    .size_i  (size_q),
    .addr_i  (bus.iMASTER_ADDR),
    .hit_o   (dec_hit),
    .owner_o (dec_owner),
    .local_o (dec_local)
  );

  assign cnt_nxt = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    base_d  = base_q;
    size_d  = size_q;
    unique case (state_q)
      ST_INIT: begin
        if (all_ready) state_d = ST_BUILD;
      end
      ST_BUILD: begin
        base_d  = base_calc;
        size_d  = size_eff;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.iMASTER_REQ) begin
          rw_d    = bus.iMASTER_RW;
          addr_d  = dec_local;
          wdata_d = bus.iMASTER_RW ? bus.iMASTER_DATA : 32'h0;
          owner_d = dec_owner;
          if (dec_hit) begin
            state_d = ST_ISSUE;
          end else begin
            rdata_d = UNMAPPED_DATA;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        if (!bus.iNODE_BUSY[owner_q]) begin
          cnt_d   = 8'd0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Completion is checked first so it beats a same-cycle timeout.
        if (bus.iNODE_REQ[owner_q]) begin
          rdata_d = node_data[owner_q];
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_nxt == TIMEOUT_CYCLE) begin
          rdata_d = UNMAPPED_DATA;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_nxt;
        end
      end
      ST_RESP: begin
        if (!bus.iMASTER_BUSY) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Request to the owner only in a cycle where it can take it.
  always_comb begin
    node_req = '0;
    if ((state_q == ST_ISSUE) && !bus.iNODE_BUSY[owner_q]) node_req[owner_q] = 1'b1;
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= ST_INIT;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      base_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      base_q  <= base_d;
      size_q  <= size_d;
    end
  end

  assign bus.oMASTER_BUSY = (state_q != ST_IDLE);
  assign bus.oREADY       = (state_q == ST_IDLE);
  assign bus.oMASTER_REQ  = (state_q == ST_RESP);
  assign bus.oMASTER_ERR  = (state_q == ST_RESP) && err_q;
  assign bus.oMASTER_DATA = rdata_q;
  assign bus.oNODE_REQ    = node_req;
  assign bus.oNODE_RW     = rw_q;
  assign bus.oNODE_ADDR   = addr_q;
  assign bus.oNODE_DATA   = wdata_q;

endmodule

// File: tb/tb_gci_hub_router.sv
// tb_gci_hub_router: directed, table-driven bench for gci_hub_router.
// Inputs change just after the rising edge; outputs are checked on the
// falling edge of the same cycle.
module tb_gci_hub_router;
  import gci_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gci_hub_router_if bus_if ();

  gci_hub_router #(
    .TIMEOUT_CYCLE (8'd8),
    .UNMAPPED_DATA (32'hFFFF_FFFF)
  ) dut (
    .iCLOCK (clk),
    .iRESET (rst),
    .bus    (bus_if)
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hit;
    int          owner;
    logic [31:0] loc;
    int          dly;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  vec_t tbl1 [8];
  vec_t tbl2 [5];
  vec_t tbl3 [2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus_if.iMASTER_REQ  = 1'b0;
    bus_if.iMASTER_RW   = 1'b0;
    bus_if.iMASTER_ADDR = '0;
    bus_if.iMASTER_DATA = '0;
    bus_if.iMASTER_BUSY = 1'b0;
    bus_if.iNODE_BUSY   = '0;
    bus_if.iNODE_REQ    = '0;
    bus_if.iNODE_DATA   = '0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_mbusy"}, bus_if.oMASTER_BUSY, 1);
    chk({tag, "_mreq"},  bus_if.oMASTER_REQ,  0);
    chk({tag, "_merr"},  bus_if.oMASTER_ERR,  0);
    chk({tag, "_ready"}, bus_if.oREADY,       0);
    chk({tag, "_nreq"},  bus_if.oNODE_REQ,    0);
    chk({tag, "_nrw"},   bus_if.oNODE_RW,     0);
    chk({tag, "_naddr"}, bus_if.oNODE_ADDR,   0);
    chk({tag, "_ndata"}, bus_if.oNODE_DATA,   0);
    chk({tag, "_mdata"}, bus_if.oMASTER_DATA, 0);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    smp();
    while (!bus_if.oREADY && n < 20) begin
      cyc();
      smp();
      n++;
    end
    chk({tag, "_ready"}, bus_if.oREADY, 1);
  endtask

  task automatic build_map(input string tag, input logic [3:0] valid, input logic [127:0] sizes);
    rst = 1'b1;
    drive_idle();
    bus_if.iNODE_VALID       = valid;
    bus_if.iNODEINFO_VALID   = '0;
    bus_if.iNODEINFO_MEMSIZE = sizes;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    bus_if.iNODEINFO_VALID = valid;
    wait_ready(tag);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [127:0] d;
    cyc();
    bus_if.iMASTER_REQ  = 1'b1;
    bus_if.iMASTER_RW   = v.rw;
    bus_if.iMASTER_ADDR = v.addr;
    bus_if.iMASTER_DATA = v.wdata;
    smp();
    chk({tag, "_accept"}, bus_if.oMASTER_BUSY, 0);
    cyc();
    bus_if.iMASTER_REQ = 1'b0;
    smp();
    if (v.hit) begin
      chk({tag, "_nreq"},  bus_if.oNODE_REQ, 4'b0001 << v.owner);
      chk({tag, "_naddr"}, bus_if.oNODE_ADDR, v.loc);
      chk({tag, "_nrw"},   bus_if.oNODE_RW, v.rw);
      chk({tag, "_ndata"}, bus_if.oNODE_DATA, v.rw ? v.wdata : 32'h0);
      chk({tag, "_mreq_issue"}, bus_if.oMASTER_REQ, 0);
      for (int k = 0; k < v.dly; k++) begin
        cyc();
        if (k == 0) begin
          // A completion from some other node must be ignored.
          bus_if.iNODE_REQ  = 4'b0001 << ((v.owner + 1) % 4);
          bus_if.iNODE_DATA = {4{32'hDEAD_BEEF}};
        end else begin
          bus_if.iNODE_REQ = '0;
        end
        smp();
        chk({tag, "_mreq_wait"}, bus_if.oMASTER_REQ, 0);
        chk({tag, "_nreq_wait"}, bus_if.oNODE_REQ, 0);
      end
      cyc();
      d = '0;
      d[v.owner*32 +: 32] = v.rdata;
      bus_if.iNODE_REQ  = 4'b0001 << v.owner;
      bus_if.iNODE_DATA = d;
      smp();
      chk({tag, "_mreq_cpl"}, bus_if.oMASTER_REQ, 0);
      cyc();
      bus_if.iNODE_REQ  = '0;
      bus_if.iNODE_DATA = '0;
      smp();
    end else begin
      chk({tag, "_nreq_none"}, bus_if.oNODE_REQ, 0);
    end
    chk({tag, "_mreq"},  bus_if.oMASTER_REQ, 1);
    chk({tag, "_mdata"}, bus_if.oMASTER_DATA, v.exp_data);
    chk({tag, "_merr"},  bus_if.oMASTER_ERR, v.exp_err);
    cyc();
    smp();
    chk({tag, "_idle"},  bus_if.oREADY, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Map 1: sizes 0x100, 0x200, absent (garbage size), 0x80.
    // Windows: n0 [0,0x100) n1 [0x100,0x300) n2 none n3 [0x300,0x380)
    tbl1[0] = '{1'b0, 32'h250, 32'h0, 1'b1, 1, 32'h150, 2, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0};
    tbl1[1] = '{1'b0, 32'h300, 32'h0, 1'b1, 3, 32'h000, 0, 32'h1234_5678, 32'h1234_5678, 1'b0};
    tbl1[2] = '{1'b1, 32'h380, 32'h1111_2222, 1'b0, 0, 32'h0, 0, 32'h0, 32'hFFFF_FFFF, 1'b1};
    tbl1[3] = '{1'b1, 32'h0FF, 32'hA5A5_A5A5, 1'b1, 0, 32'h0FF, 1, 32'h0, 32'h0, 1'b0};
    tbl1[4] = '{1'b0, 32'h100, 32'h0, 1'b1, 1, 32'h000, 3, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
    tbl1[5] = '{1'b0, 32'h37F, 32'h0, 1'b1, 3, 32'h07F, 0, 32'h7F7F_0000, 32'h7F7F_0000, 1'b0};
    tbl1[6] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 0, 32'h0, 0, 32'h0, 32'hFFFF_FFFF, 1'b1};
    tbl1[7] = '{1'b1, 32'h2FF, 32'h0102_0304, 1'b1, 1, 32'h1FF, 0, 32'h0, 32'h0, 1'b0};
    // Map 2: sizes 0x40, 0x200, 0x100, 0x80 all present.
    // Windows: n0 [0,0x40) n1 [0x40,0x240) n2 [0x240,0x340) n3 [0x340,0x3C0)
    tbl2[0] = '{1'b0, 32'h250, 32'h0, 1'b1, 2, 32'h010, 1, 32'h2222_0010, 32'h2222_0010, 1'b0};
    tbl2[1] = '{1'b0, 32'h3BF, 32'h0, 1'b1, 3, 32'h07F, 0, 32'h3333_007F, 32'h3333_007F, 1'b0};
    tbl2[2] = '{1'b0, 32'h3C0, 32'h0, 1'b0, 0, 32'h0, 0, 32'h0, 32'hFFFF_FFFF, 1'b1};
    tbl2[3] = '{1'b0, 32'h040, 32'h0, 1'b1, 1, 32'h000, 0, 32'h1111_0000, 32'h1111_0000, 1'b0};
    tbl2[4] = '{1'b0, 32'h03F, 32'h0, 1'b1, 0, 32'h03F, 0, 32'h0000_003F, 32'h0000_003F, 1'b0};
    // Map 3: n0 size 0xFFFFFFFF, n1 size 0x10 -> n1 window clipped to [0xFFFFFFFF, 2^32)
    tbl3[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 32'h0, 0, 32'h5A5A_0001, 32'h5A5A_0001, 1'b0};
    tbl3[1] = '{1'b1, 32'hFFFF_FFFE, 32'h7777_8888, 1'b1, 0, 32'hFFFF_FFFE, 0, 32'h0, 32'h0, 1'b0};

    // Reset values and ready timing.
    rst = 1'b1;
    drive_idle();
    bus_if.iNODE_VALID       = 4'b1011;
    bus_if.iNODEINFO_VALID   = 4'b0000;
    bus_if.iNODEINFO_MEMSIZE = {32'h80, 32'h1000, 32'h200, 32'h100};
    repeat (3) @(posedge clk);
    smp();
    chk_reset_outs("reset");
    cyc();
    rst = 1'b0;
    smp();
    chk("init_ready0", bus_if.oREADY, 0);
    cyc();
    smp();
    chk("init_ready1", bus_if.oREADY, 0);
    cyc();
    bus_if.iNODEINFO_VALID = 4'b1011;
    smp();
    chk("info_ready_T0", bus_if.oREADY, 0);
    cyc();
    smp();
    chk("build_ready", bus_if.oREADY, 0);
    chk("build_busy", bus_if.oMASTER_BUSY, 1);
    cyc();
    smp();
    chk("idle_ready", bus_if.oREADY, 1);
    chk("idle_busy", bus_if.oMASTER_BUSY, 0);

    for (int i = 0; i < 8; i++) run_vec($sformatf("map1_v%0d", i), tbl1[i]);

    // Node0 busy for 5 cycles while the request waits in ISSUE.
    cyc();
    bus_if.iMASTER_REQ  = 1'b1;
    bus_if.iMASTER_RW   = 1'b1;
    bus_if.iMASTER_ADDR = 32'h10;
    bus_if.iMASTER_DATA = 32'h5555_AAAA;
    bus_if.iNODE_BUSY   = 4'b0001;
    smp();
    chk("busy_accept", bus_if.oMASTER_BUSY, 0);
    cyc();
    bus_if.iMASTER_REQ = 1'b0;
    smp();
    chk("busy_nreq_c0", bus_if.oNODE_REQ, 0);
    chk("busy_naddr_c0", bus_if.oNODE_ADDR, 32'h10);
    for (int k = 1; k < 5; k++) begin
      cyc();
      smp();
      chk($sformatf("busy_nreq_c%0d", k), bus_if.oNODE_REQ, 0);
      chk($sformatf("busy_naddr_c%0d", k), bus_if.oNODE_ADDR, 32'h10);
    end
    cyc();
    bus_if.iNODE_BUSY = 4'b0000;
    smp();
    chk("busy_issue_nreq", bus_if.oNODE_REQ, 4'b0001);
    chk("busy_issue_naddr", bus_if.oNODE_ADDR, 32'h10);
    chk("busy_issue_ndata", bus_if.oNODE_DATA, 32'h5555_AAAA);
    chk("busy_issue_nrw", bus_if.oNODE_RW, 1);
    cyc();
    bus_if.iNODE_REQ  = 4'b0001;
    bus_if.iNODE_DATA = '0;
    smp();
    chk("busy_wait_nreq", bus_if.oNODE_REQ, 0);
    chk("busy_wait_naddr", bus_if.oNODE_ADDR, 32'h10);
    cyc();
    bus_if.iNODE_REQ = '0;
    smp();
    chk("busy_mreq", bus_if.oMASTER_REQ, 1);
    chk("busy_mdata", bus_if.oMASTER_DATA, 0);
    chk("busy_merr", bus_if.oMASTER_ERR, 0);
    cyc();
    smp();
    chk("busy_idle", bus_if.oREADY, 1);

    // Timeout (8) followed by master busy for 3 cycles in RESP.
    cyc();
    bus_if.iMASTER_REQ  = 1'b1;
    bus_if.iMASTER_RW   = 1'b0;
    bus_if.iMASTER_ADDR = 32'h200;
    smp();
    chk("to_accept", bus_if.oMASTER_BUSY, 0);
    cyc();
    bus_if.iMASTER_REQ = 1'b0;
    smp();
    chk("to_issue_nreq", bus_if.oNODE_REQ, 4'b0010);
    chk("to_issue_naddr", bus_if.oNODE_ADDR, 32'h100);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      smp();
      chk($sformatf("to_wait%0d_mreq", k), bus_if.oMASTER_REQ, 0);
    end
    cyc();
    bus_if.iMASTER_BUSY = 1'b1;
    smp();
    chk("to_mreq", bus_if.oMASTER_REQ, 1);
    chk("to_merr", bus_if.oMASTER_ERR, 1);
    chk("to_mdata", bus_if.oMASTER_DATA, 32'hFFFF_FFFF);
    for (int k = 1; k <= 2; k++) begin
      cyc();
      smp();
      chk($sformatf("hold%0d_mreq", k), bus_if.oMASTER_REQ, 1);
      chk($sformatf("hold%0d_mdata", k), bus_if.oMASTER_DATA, 32'hFFFF_FFFF);
      chk($sformatf("hold%0d_mbusy", k), bus_if.oMASTER_BUSY, 1);
    end
    cyc();
    bus_if.iMASTER_BUSY = 1'b0;
    smp();
    chk("hold3_mreq", bus_if.oMASTER_REQ, 1);
    chk("hold3_mdata", bus_if.oMASTER_DATA, 32'hFFFF_FFFF);
    cyc();
    smp();
    chk("hold_done_mreq", bus_if.oMASTER_REQ, 0);
    chk("hold_done_ready", bus_if.oREADY, 1);

    // Reset in the middle of WAIT.
    cyc();
    bus_if.iMASTER_REQ  = 1'b1;
    bus_if.iMASTER_RW   = 1'b0;
    bus_if.iMASTER_ADDR = 32'h250;
    smp();
    cyc();
    bus_if.iMASTER_REQ = 1'b0;
    smp();
    chk("rw_issue_nreq", bus_if.oNODE_REQ, 4'b0010);
    cyc();
    smp();
    cyc();
    rst = 1'b1;
    bus_if.iNODE_REQ  = 4'b0010;
    bus_if.iNODE_DATA = {4{32'hCAFE_0001}};
    smp();
    chk_reset_outs("rst_wait");
    cyc();
    bus_if.iNODE_REQ = '0;
    smp();
    chk("rst_wait_nocpl", bus_if.oMASTER_REQ, 0);

    build_map("map2", 4'b1111, {32'h80, 32'h100, 32'h200, 32'h40});
    for (int i = 0; i < 5; i++) run_vec($sformatf("map2_v%0d", i), tbl2[i]);

    build_map("map3", 4'b0011, {32'h100, 32'h100, 32'h10, 32'hFFFF_FFFF});
    for (int i = 0; i < 2; i++) run_vec($sformatf("map3_v%0d", i), tbl3[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gci_hub_router.md
# gci_hub_router

Master-side router sitting directly upstream of up to four `gci_node` instances. It takes single-outstanding read/write requests from one bus master and computes each node's address window from the node's reported memory size. It forwards each request to the owning node with a node-local address, waits for that node's completion pulse, and returns the result to the master. Unmapped accesses and node timeouts complete with an error value, so the master never hangs.

## Interface
- `TIMEOUT_CYCLE`, default `8'hFF`: maximum number of cycles to wait for a node completion after issue.
- `UNMAPPED_DATA`, default `32'hFFFFFFFF`: data returned on an unmapped access or a timeout.
- `iCLOCK` in, 1: the single clock.
- `iRESET` in, 1: asynchronous, active-high reset.
- `iMASTER_REQ` in, 1: request strobe from the master.
- `oMASTER_BUSY` out, 1: router cannot accept a request.
- `iMASTER_RW` in, 1: 1 = write, 0 = read.
- `iMASTER_ADDR` in, 32: global address.
- `iMASTER_DATA` in, 32: write data.
- `oMASTER_REQ` out, 1: completion strobe.
- `iMASTER_BUSY` in, 1: master cannot take the completion.
- `oMASTER_DATA` out, 32: read data (write → 0).
- `oMASTER_ERR` out, 1: completion is unmapped or timed out; qualified by `oMASTER_REQ`.
- `oREADY` out, 1: address map built and the router is accepting requests.
- `iNODE_VALID` in, 4: per-node present flag (node's `oNODE_VALID`).
- `iNODEINFO_VALID` in, 4: per-node initialisation done.
- `iNODEINFO_MEMSIZE` in, 128: node i size in bits [32i+31:32i].
- `oNODE_REQ` out, 4: one-hot request to node i.
- `iNODE_BUSY` in, 4: node i's `oMASTER_BUSY`.
- `oNODE_RW` out, 1: broadcast read/write flag.
- `oNODE_ADDR` out, 32: broadcast node-local address.
- `oNODE_DATA` out, 32: broadcast write data.
- `iNODE_REQ` in, 4: node i completion pulse.
- `iNODE_DATA` in, 128: node i read data.

## Operation
- States: INIT, BUILD, IDLE, ISSUE, WAIT, RESP.
- **INIT**
  - Stay in INIT until every node satisfies `!iNODE_VALID[i] || iNODEINFO_VALID[i]`.
  - When that holds, go to BUILD.
- **BUILD** (one cycle)
  - Latch the window bases.
  - base0 = 0; base(i+1) = base(i) + size(i), where size(i) = memsize if `iNODE_VALID[i]`, else 0.
  - Sums are computed in 33 bits; a window end above `2^32` is clipped to `2^32`.
  - Zero-size nodes own no addresses.
  - Then go to IDLE.
- **IDLE**
  - `oREADY` = 1.
  - `iMASTER_REQ && !oMASTER_BUSY` latches RW, addr and data.
  - Owner = the lowest i with base(i) ≤ addr < base(i)+size(i).
  - Local address = addr − base(owner).
  - Owner found → ISSUE. No owner → RESP with `oMASTER_ERR` = 1 and data = `UNMAPPED_DATA`.
- **ISSUE**
  - `oNODE_REQ[owner]` is asserted only in a cycle where `iNODE_BUSY[owner]` = 0.
  - That cycle is the issue; the next state is WAIT.
  - `oNODE_ADDR`, `oNODE_DATA` and `oNODE_RW` are held stable from ISSUE through the end of WAIT.
  - In ISSUE, a read drives `oNODE_DATA` = 0.
- **WAIT**
  - A counter starts at 0 and increments each cycle.
  - `iNODE_REQ[owner]` → capture the owner's data slice → RESP with `oMASTER_ERR` = 0.
  - Counter reaching `TIMEOUT_CYCLE` without a completion → RESP with `oMASTER_ERR` = 1 and data = `UNMAPPED_DATA`.
  - `iNODE_REQ` from any non-owner node is ignored.
  - If the owner's completion and the timeout occur in the same cycle, the completion wins.
- **RESP**
  - `oMASTER_REQ` = 1 and the data is held until a cycle with `iMASTER_BUSY` = 0.
  - In that cycle, go to IDLE.
- `oMASTER_BUSY` = !(state == IDLE).
- A write completion returns the node's data, which is 0.
- Reset at any point: all state clears and the router re-enters INIT. A transaction in flight is dropped and no completion is produced.

## Timing
- Reset values of the outputs:
  - `oMASTER_BUSY` = 1.
  - `oMASTER_REQ`, `oMASTER_ERR`, `oREADY` = 0.
  - `oNODE_REQ` = 0.
  - `oNODE_RW` = 0.
  - `oNODE_ADDR`, `oNODE_DATA`, `oMASTER_DATA` = 0.
- After all nodes are ready, `oREADY` rises 2 cycles later (INIT → BUILD → IDLE).
- Accepted request in cycle T:
  - Owner not busy: `oNODE_REQ` asserted at T+1.
  - Unmapped: `oMASTER_REQ` asserted at T+1.
- Node completion pulse in cycle C: `oMASTER_REQ` asserted at C+1.
- Back-to-back requests: the earliest new acceptance is the cycle after the `oMASTER_REQ` handshake completes.
- Only one request is outstanding at a time.

## Structure
- Package `gci_pkg` holds:
  - the state encodings;
  - `GCI_NODE_NUM` = 4;
  - the node-register offsets (MEMSIZE 0x0, PRIORITY 0x4, INTFLAG 0x8).
- Sub-module `gci_hub_addr_decoder`: a purely combinational block taking the latched bases, sizes and an address, and producing a valid flag, the owner index and the local address.
- The FSM, timeout counter and data registers live in `gci_hub_router`.

## Test plan
- Sizes 0x100, 0x200, absent, 0x80:
  - Read at 0x250 → node1 receives local address 0x150, and its data 0xCAFE0001 is returned with ERR = 0.
  - Read at 0x300 → node3 receives local address 0x000.
- Write at 0x380 with the same map → unmapped: `oMASTER_REQ` at T+1, data 0xFFFFFFFF, ERR = 1, no `oNODE_REQ` pulse.
- Node0 holds `iNODE_BUSY` = 1 for 5 cycles → `oNODE_REQ[0]` is asserted only in the first cycle after busy drops; the address stays stable throughout.
- Node never completes, `TIMEOUT_CYCLE` = 8 → ERR completion 9 cycles after issue.
- `iMASTER_BUSY` held high for 3 cycles in RESP → `oMASTER_REQ` and data held for 4 cycles, then IDLE.
- Reset asserted during WAIT → outputs return to reset values; after reset, rebuilding the map yields correct bases.
